// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares a 32x32 register file (2R/1W, 1-cycle registered read)
// between the CPU core (requester 0) and the debug unit (requester 1).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   core_valid/core_ready         core request handshake (ready is combinational)
//   core_ra0/ra1/we/wa/wd         core read addresses and write request
//   core_rsp_valid/core_rd0/rd1   core read response, one cycle after the grant
//   dbg_*                         same groups for the debug requester
//   rf_ra0/ra1/wa/wd/we           register file drive
//   rf_rd0/rf_rd1                 register file read data (cycle after address)
module rf_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [4:0]  core_ra0,
  input  logic [4:0]  core_ra1,
  input  logic        core_we,
  input  logic [4:0]  core_wa,
  input  logic [31:0] core_wd,
  output logic        core_rsp_valid,
  output logic [31:0] core_rd0,
  output logic [31:0] core_rd1,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [4:0]  dbg_ra0,
  input  logic [4:0]  dbg_ra1,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_wa,
  input  logic [31:0] dbg_wd,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rd0,
  output logic [31:0] dbg_rd1,
  output logic [4:0]  rf_ra0,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        rf_we,
  input  logic [31:0] rf_rd0,
  input  logic [31:0] rf_rd1
);

  logic [3:0]  starve_q, starve_d;
  logic        pend_q, pend_d;
  logic        owner_q, owner_d;
  logic        zero0_q, zero0_d, zero1_q, zero1_d;
  logic        fwd0_q, fwd0_d, fwd1_q, fwd1_d;
  logic [31:0] fwd_data_q, fwd_data_d;

  logic        starved;
  logic        granted;
  logic [4:0]  g_ra0, g_ra1, g_wa;
  logic        g_we;
  logic [31:0] g_wd;
  logic [31:0] data0, data1;

  assign starved = (starve_q == 4'(STARVE_MAX));

  // Grant: core has priority unless debug has waited STARVE_MAX cycles.
  always_comb begin
    core_ready = !rst && core_valid && !(dbg_valid && starved);
    dbg_ready  = !rst && dbg_valid && (!core_valid || starved);
    granted    = core_ready || dbg_ready;
  end

  always_comb begin
    g_ra0 = dbg_ready ? dbg_ra0 : core_ra0;
    g_ra1 = dbg_ready ? dbg_ra1 : core_ra1;
    g_we  = dbg_ready ? dbg_we  : core_we;
    g_wa  = dbg_ready ? dbg_wa  : core_wa;
    g_wd  = dbg_ready ? dbg_wd  : core_wd;
  end

  always_comb begin
    rf_ra0 = granted ? g_ra0 : 5'd0;
    rf_ra1 = granted ? g_ra1 : 5'd0;
    rf_wa  = granted ? g_wa  : 5'd0;
    rf_wd  = granted ? g_wd  : 32'd0;
    rf_we  = granted && g_we && (g_wa != 5'd0);
  end

  always_comb begin
    starve_d = starve_q;
    if (dbg_ready || !dbg_valid) begin
      starve_d = 4'd0;
    end else if (!starved) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Response pipeline. The RF reads old contents on a same-cycle write, so the
  // write data is captured here and substituted on the response.
  always_comb begin
    pend_d     = granted;
    owner_d    = granted ? dbg_ready : owner_q;
    zero0_d    = (g_ra0 == 5'd0);
    zero1_d    = (g_ra1 == 5'd0);
    fwd0_d     = rf_we && (g_wa == g_ra0);
    fwd1_d     = rf_we && (g_wa == g_ra1);
    fwd_data_d = g_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= 4'd0;
      pend_q     <= 1'b0;
      owner_q    <= 1'b0;
      zero0_q    <= 1'b0;
      zero1_q    <= 1'b0;
      fwd0_q     <= 1'b0;
      fwd1_q     <= 1'b0;
      fwd_data_q <= 32'd0;
    end else begin
      starve_q   <= starve_d;
      pend_q     <= pend_d;
      owner_q    <= owner_d;
      zero0_q    <= zero0_d;
      zero1_q    <= zero1_d;
      fwd0_q     <= fwd0_d;
      fwd1_q     <= fwd1_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  always_comb begin
    data0 = zero0_q ? 32'd0 : (fwd0_q ? fwd_data_q : rf_rd0);
    data1 = zero1_q ? 32'd0 : (fwd1_q ? fwd_data_q : rf_rd1);
    core_rsp_valid = pend_q && !owner_q;
    dbg_rsp_valid  = pend_q && owner_q;
    // Data is gated by valid so idle and reset cycles present zeros.
    core_rd0 = core_rsp_valid ? data0 : 32'd0;
    core_rd1 = core_rsp_valid ? data1 : 32'd0;
    dbg_rd0  = dbg_rsp_valid  ? data0 : 32'd0;
    dbg_rd1  = dbg_rsp_valid  ? data1 : 32'd0;
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter: a register-file model drives rf_rd*,
// an architectural model predicts grants and read data, and a monitor pops the
// expected responses from a scoreboard queue.
module tb_rf_port_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  typedef struct packed {
    logic        v;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } req_t;

  typedef struct packed {
    int          due;
    logic        owner;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_valid = 0, core_we = 0, dbg_valid = 0, dbg_we = 0;
  logic [4:0]  core_ra0 = 0, core_ra1 = 0, core_wa = 0;
  logic [4:0]  dbg_ra0 = 0, dbg_ra1 = 0, dbg_wa = 0;
  logic [31:0] core_wd = 0, dbg_wd = 0;
  logic        core_ready, dbg_ready, core_rsp_valid, dbg_rsp_valid;
  logic [31:0] core_rd0, core_rd1, dbg_rd0, dbg_rd1;
  logic [4:0]  rf_ra0, rf_ra1, rf_wa;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic [31:0] rf_rd0 = 0, rf_rd1 = 0;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int wait_cnt = 0;
  logic [31:0] rf_mem [32];
  logic [31:0] arch [32];
  exp_t sb [$];

  rf_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_ra0(core_ra0), .core_ra1(core_ra1),
    .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd),
    .core_rsp_valid(core_rsp_valid), .core_rd0(core_rd0), .core_rd1(core_rd1),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_ra0(dbg_ra0), .dbg_ra1(dbg_ra1),
    .dbg_we(dbg_we), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rd0(dbg_rd0), .dbg_rd1(dbg_rd1),
    .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
    .rf_rd0(rf_rd0), .rf_rd1(rf_rd1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: registered read returns the pre-write contents.
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_wa] <= rf_wd;
    rf_rd0 <= rf_mem[rf_ra0];
    rf_rd1 <= rf_mem[rf_ra1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      chk("rsp_valid_in_reset", {30'd0, core_rsp_valid, dbg_rsp_valid}, 32'd0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("core_rsp_valid", {31'd0, core_rsp_valid}, {31'd0, !e.owner});
      chk("dbg_rsp_valid", {31'd0, dbg_rsp_valid}, {31'd0, e.owner});
      chk("owner_rd0", e.owner ? dbg_rd0 : core_rd0, e.rd0);
      chk("owner_rd1", e.owner ? dbg_rd1 : core_rd1, e.rd1);
      chk("other_rd", e.owner ? (core_rd0 | core_rd1) : (dbg_rd0 | dbg_rd1), 32'd0);
    end else begin
      chk("idle_rsp_valid", {30'd0, core_rsp_valid, dbg_rsp_valid}, 32'd0);
      chk("idle_rd", core_rd0 | core_rd1 | dbg_rd0 | dbg_rd1, 32'd0);
    end
  end

  function automatic logic [31:0] model_read(input req_t r, input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (r.we && r.wa == ra) return r.wd;
    return arch[ra];
  endfunction

  // Apply one cycle of requests, check the grant against the arbitration rules,
  // and queue the expected response.
  task automatic step(input req_t c, input req_t d);
    logic force_dbg, gc, gd, exp_we;
    req_t g;
    exp_t e;
    core_valid = c.v; core_ra0 = c.ra0; core_ra1 = c.ra1;
    core_we = c.we; core_wa = c.wa; core_wd = c.wd;
    dbg_valid = d.v; dbg_ra0 = d.ra0; dbg_ra1 = d.ra1;
    dbg_we = d.we; dbg_wa = d.wa; dbg_wd = d.wd;
    @(negedge clk);
    force_dbg = d.v && (wait_cnt == STARVE_MAX);
    gc = c.v && !force_dbg;
    gd = d.v && (!c.v || force_dbg);
    chk("core_ready", {31'd0, core_ready}, {31'd0, gc});
    chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, gd});
    g = gd ? d : c;
    exp_we = (gc || gd) && g.we && (g.wa != 5'd0);
    chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
    if (gc || gd) begin
      e.due = cyc + 1;
      e.owner = gd;
      e.rd0 = model_read(g, g.ra0);
      e.rd1 = model_read(g, g.ra1);
      sb.push_back(e);
      if (exp_we) arch[g.wa] = g.wd;
    end
    if (d.v && !gd) wait_cnt = (wait_cnt < STARVE_MAX) ? wait_cnt + 1 : wait_cnt;
    else wait_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mk(input logic v, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd);
    req_t r;
    r.v = v; r.ra0 = ra0; r.ra1 = ra1; r.we = we; r.wa = wa; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rnd_req(input int pct_valid);
    return mk(($urandom_range(0, 99) < pct_valid), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), $urandom);
  endfunction

  // Hold reset with both valids high; readies and rf_we must stay low.
  task automatic reset_phase();
    rst = 1'b1;
    sb.delete();
    wait_cnt = 0;
    core_valid = 1'b1; core_we = 1'b1; core_wa = 5'd9;
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_wa = 5'd9;
    repeat (2) begin
      @(negedge clk);
      chk("ready_in_reset", {30'd0, core_ready, dbg_ready}, 32'd0);
      chk("rf_we_in_reset", {31'd0, rf_we}, 32'd0);
    end
    core_valid = 1'b0; dbg_valid = 1'b0; core_we = 1'b0; dbg_we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  req_t idle;

  initial begin
    idle = '0;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'd0;
      arch[i] = 32'd0;
    end
    reset_phase();

    // Core alone: write then read back.
    step(mk(1, 0, 0, 1, 5, 32'hDEADBEEF), idle);
    step(mk(1, 5, 0, 0, 0, 0), idle);
    step(idle, idle);

    // Same-cycle forward over a stale RF value.
    step(mk(1, 0, 0, 1, 7, 32'h0000_0055), idle);
    step(mk(1, 7, 7, 1, 7, 32'h12345678), idle);
    step(idle, idle);

    // x0 protection from the debug side.
    step(idle, mk(1, 0, 0, 1, 0, 32'hFFFFFFFF));
    step(idle, mk(1, 0, 0, 0, 0, 0));
    step(idle, idle);

    // Starvation: both valid continuously.
    for (int i = 0; i < 15; i++) step(mk(1, 5, 7, 0, 0, 0), mk(1, 7, 5, 0, 0, 0));
    step(idle, idle);

    // Interleave: core writes x3 in its last slot, debug is forced next cycle.
    for (int i = 0; i < 3; i++) step(mk(1, 1, 2, 0, 0, 0), mk(1, 3, 0, 0, 0, 0));
    step(mk(1, 0, 0, 1, 3, 32'h0000_000A), mk(1, 3, 0, 0, 0, 0));
    step(mk(1, 1, 2, 0, 0, 0), mk(1, 3, 0, 0, 0, 0));
    step(idle, idle);

    // Reset mid-flight: response of the last grant is dropped.
    step(mk(1, 5, 7, 0, 0, 0), mk(1, 3, 3, 0, 0, 0));
    reset_phase();
    for (int i = 0; i < 6; i++) step(mk(1, 5, 3, 0, 0, 0), mk(1, 7, 3, 0, 0, 0));

    // Randomized traffic over a small address range to hit forwarding and x0.
    for (int i = 0; i < 400; i++) step(rnd_req(70), rnd_req(60));

    step(idle, idle);
    step(idle, idle);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the synchronous 32x32 register file (2 read ports, 1 write port, 1-cycle registered read latency) between two requesters: the CPU core (requester 0) and the debug unit (requester 1).
- Grants at most one requester per cycle and drives the register file address, write and data lines.
- Returns read data one cycle after the grant, tagged to the granted requester.
- Enforces x0 = 0 and forwards same-cycle writes that the register file itself would miss.

Parameters:
- STARVE_MAX, 4: number of consecutive cycles the debug requester may wait before it takes priority over the core (1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- core_valid  input  1  core request valid
- core_ready  output  1  core request granted this cycle (combinational)
- core_ra0, core_ra1  input  5 each  core read addresses
- core_we  input  1  core write enable
- core_wa  input  5  core write address
- core_wd  input  32  core write data
- core_rsp_valid  output  1  core read data valid
- core_rd0, core_rd1  output  32 each  core read data
- dbg_valid, dbg_ready, dbg_ra0, dbg_ra1, dbg_we, dbg_wa, dbg_wd  same widths and meanings as the core_* request group, for the debug requester
- dbg_rsp_valid, dbg_rd0, dbg_rd1  same widths and meanings as the core_* response group
- rf_ra0, rf_ra1  output  5 each  register file read addresses
- rf_wa  output  5  register file write address
- rf_wd  output  32  register file write data
- rf_we  output  1  register file write enable
- rf_rd0, rf_rd1  input  32 each  register file read data (valid the cycle after the address is applied)

Behaviour:
- Request acceptance: a request is accepted in cycle N when valid && ready. Ready is combinational from valid and the starvation state, and never depends on ready of the same requester.
- Grant, core side: core_ready = core_valid && !(dbg_valid && starve_cnt == STARVE_MAX).
- Grant, debug side: dbg_ready = dbg_valid && (!core_valid || starve_cnt == STARVE_MAX).
- Grant exclusivity: at most one grant per cycle; both ready high together is a bug.
- Starvation counter (4 bits, reset 0):
  - clears when dbg_ready or !dbg_valid;
  - otherwise increments, saturating at STARVE_MAX.
- RF drive when granted: the granted requester's ra0/ra1/wa/wd are muxed to rf_*.
- RF drive when idle: rf_ra0/rf_ra1/rf_wa = 0, rf_wd = 0, rf_we = 0.
- Write enable: rf_we = granted && we && (wa != 0). Writes to x0 are suppressed.
- Response pipeline register, loaded at the clock edge that ends grant cycle N. Fields:
  - owner (1 bit);
  - pend (1 bit);
  - zero0/zero1: read address == 0;
  - fwd0/fwd1: rf_we && wa == ra0 / ra1;
  - fwd_data: wd.
- Response in cycle N+1: owner's rsp_valid = pend, held for exactly one cycle.
- Response data, port 0: rd0 = zero0 ? 0 : fwd0 ? fwd_data : rf_rd0. Port 1 is identical using zero1/fwd1/rf_rd1.
- Non-owner's rd outputs are 0 and its rsp_valid is 0.
- Throughput: back-to-back grants are allowed (one per cycle); responses pipeline without bubbles.
- Ordering: a write accepted in cycle N is visible to any read accepted in cycle N (via forwarding) and in N+1 onward (via the register file). Read-after-write across requesters needs no extra stall.
- Reset values (async): pend = 0, owner = 0, starve_cnt = 0, core_rsp_valid = 0, dbg_rsp_valid = 0, all rd outputs = 0.
- Reset while asserted: rf_we = 0 and both ready = 0 regardless of valid.
- Reset mid-operation: an outstanding response is dropped. The requester must reissue after reset.
- Simultaneous valid: core wins unless the counter is saturated, in which case debug wins for exactly one cycle and the counter clears.

Test Plan:
- Core alone:
  - stimulus: write x5 = 0xDEADBEEF, next cycle read ra0 = 5, ra1 = 0;
  - required: core_ready both cycles; core_rsp_valid in the cycle after the read; core_rd0 = 0xDEADBEEF, core_rd1 = 0.
- Same-cycle forward:
  - stimulus: core we = 1, wa = 7, wd = 0x12345678, ra0 = ra1 = 7 in one request;
  - required: next-cycle core_rd0 = core_rd1 = 0x12345678 (not the stale RF value).
- x0 protection:
  - stimulus: dbg write wa = 0, wd = 0xFFFFFFFF; then dbg read ra0 = 0;
  - required: rf_we = 0 in the write cycle; dbg_rd0 = 0.
- Starvation (STARVE_MAX = 4):
  - stimulus: core_valid and dbg_valid held high continuously;
  - required: core granted 4 cycles, dbg granted in cycle 5, pattern repeats every 5 cycles; responses alternate owner correctly.
- Interleave:
  - stimulus: core writes x3 = 0xA in cycle N; dbg (starvation-forced) reads x3 in cycle N+1;
  - required: dbg_rd0 = 0xA in N+2, core_rsp_valid = 1 only in N+1.
- Reset mid-flight:
  - stimulus: assert rst in the cycle after a core read grant;
  - required: core_rsp_valid stays 0; starve_cnt = 0; after release, first request behaves as from reset.
